game_control_timed: RTL and testbench
=====================================

// Module: game_control_timed
// PURPOSE
//  Top-level game FSM for the sequence-recall game, next generation of the game controller.
//  - Owns the score, mistake and level counters (previously external).
//  - Adds a per-round response timeout (counts as a mistake), a parametrised mistake limit,
//    and level-up tracking for the sequence generator / display.
//  - Sits between the button debouncers, the sequence generator/checker and the 7-seg/LED display.
// PARAMETERS
//  MAX_MISTAKES  3      mistakes that end the game (>=1)
//  SCORE_W       8      score counter width; score saturates at 2**SCORE_W-1
//  TIMEOUT_CYC   50e6   clk cycles allowed in PAUSE before timeout; 0 disables timeout
//  TIMER_W       26     width of response timer / time_left (must hold TIMEOUT_CYC)
//  LEVEL_STEP    4      correct answers per level increment (>=1)
//  MAX_LEVEL     7      level saturates here; LEVEL_W = $clog2(MAX_LEVEL+1)
// PORTS
//  clk             in   1        system clock
//  reset           in   1        asynchronous, active-low reset
//  enter           in   1        debounced enter button, level (rising edge used)
//  sequence_check  in   1        1 = player input matches generated sequence
//  sequence_ld     out  1        1-cycle strobe: generator loads new sequence
//  score_ld        out  1        1-cycle strobe: correct answer scored
//  mistakes_ld     out  1        1-cycle strobe: mistake recorded (wrong or timeout)
//  timeout         out  1        1-cycle strobe: round ended by timeout
//  game_over       out  1        high while in DONE
//  score           out  SCORE_W  current score
//  mistakes        out  MIST_W   current mistakes, MIST_W=$clog2(MAX_MISTAKES+1)
//  level           out  LEVEL_W  current level, starts 0
//  time_left       out  TIMER_W  TIMEOUT_CYC - elapsed PAUSE cycles; 0 outside PAUSE
//  state_out       out  5        current state encoding
// BEHAVIOUR
//  - Reset (async, reset==0): state=HALTED, enter_prev=0. All strobes, game_over, score,
//    mistakes, level, time_left and timer are 0.
//  - Enter edge: enter_prev registered each clk; edge = enter & ~enter_prev.
//    A held button never counts twice.
//  - States/encoding: HALTED=0, GENERATE=1, PAUSE=2, CHECK=3, UPDATE=4, DONE=5, TIMEOUT=6.
//    Any other encoding -> HALTED next cycle.
//  - HALTED: clear score, mistakes, level, timer -> GENERATE.
//  - GENERATE: sequence_ld=1; timer cleared -> PAUSE.
//  - PAUSE: timer +1 per cycle; time_left = TIMEOUT_CYC - timer.
//    - enter edge -> CHECK. An edge takes priority over expiry in the same cycle.
//    - else if TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1 -> TIMEOUT.
//    - else stay.
//  - CHECK: latch sequence_check into check_q -> UPDATE.
//    UPDATE uses check_q only; sequence_check is ignored there.
//  - UPDATE, check_q==1:
//    - score_ld=1; score+1, saturating (score_ld still pulses at max).
//    - If the post-increment score is a nonzero multiple of LEVEL_STEP, level+1, saturating at MAX_LEVEL.
//    -> GENERATE.
//  - UPDATE, check_q==0: mistakes_ld=1; mistakes+1.
//    - New value == MAX_MISTAKES -> DONE, else -> GENERATE.
//  - TIMEOUT: timeout=1 and mistakes_ld=1 (same cycle); mistakes+1; same DONE/GENERATE rule as UPDATE.
//  - DONE: game_over=1; counters hold for display; enter edge -> HALTED, else stay.
//  - Counters change only on the clk edge ending UPDATE/TIMEOUT/HALTED; all outputs registered or
//    decoded from registered state.
//  - Strobes: exactly one cycle, at most one of score_ld/mistakes_ld per round.
//  - mistakes never exceeds MAX_MISTAKES.
//  - Latency: enter edge in PAUSE -> score_ld/mistakes_ld 2 cycles later (CHECK, UPDATE).
//  - Reset asserted mid-game: immediate return to the reset values above; no strobe is emitted
//    on the release cycle.
// TESTING (TIMEOUT_CYC=8, MAX_MISTAKES=3, LEVEL_STEP=2, MAX_LEVEL=3, SCORE_W=4)
//  1. Release reset, hold enter=0 -> state 0,1,2; sequence_ld high 1 cycle; time_left=8,7,...
//  2. Enter edge with check=1, repeated 5 rounds -> score 1..5, level 0,1,1,2,2; no mistakes_ld.
//  3. No enter for 8 PAUSE cycles -> TIMEOUT (6): timeout+mistakes_ld pulse; mistakes=1; -> GENERATE.
//  4. Three wrong answers (check=0) -> mistakes 1,2,3; then DONE, game_over=1; enter edge -> HALTED,
//     counters 0.
//  5. Enter held high through GENERATE into PAUSE -> no CHECK until released and re-pressed.
//     Edge on expiry cycle -> CHECK, not TIMEOUT.
//  6. 16 correct rounds -> score saturates at 15, score_ld still pulses, level stays 3.
//     reset=0 mid-PAUSE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/game_control_timed.sv
// game_control_timed
// Top-level controller for the sequence-recall game. It runs one round per
// generated sequence: it asks the generator for a new sequence, waits for the
// player to press enter within the response window, samples the checker's
// verdict and then updates the score, mistake and level counters it owns.
// A round with no answer before the window closes counts as a mistake.
// When the mistake limit is reached the game parks in DONE until enter is
// pressed again.
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   enter_i          debounced enter button (level, rising edge used)
//   sequenceCheck_i  1 = player input matches the generated sequence
//   sequenceLd_o     1-cycle strobe, generator loads a new sequence
//   scoreLd_o        1-cycle strobe, correct answer scored
//   mistakesLd_o     1-cycle strobe, mistake recorded (wrong answer or timeout)
//   timeout_o        1-cycle strobe, round ended by timeout
//   gameOver_o       high while the game is over (DONE)
//   score_o          current score, saturating
//   mistakes_o       current mistake count
//   level_o          current level, saturating at MAX_LEVEL
//   timeLeft_o       cycles remaining in the response window, 0 outside PAUSE
//   stateOut_o       current state encoding
module game_control_timed #(
    parameter int MAX_MISTAKES = 3,
    parameter int SCORE_W      = 8,
    parameter int TIMEOUT_CYC  = 50_000_000,
    parameter int TIMER_W      = 26,
    parameter int LEVEL_STEP   = 4,
    parameter int MAX_LEVEL    = 7,
    localparam int MIST_W      = $clog2(MAX_MISTAKES + 1),
    localparam int LEVEL_W     = $clog2(MAX_LEVEL + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enter_i,
    input  logic               sequenceCheck_i,
    output logic               sequenceLd_o,
    output logic               scoreLd_o,
    output logic               mistakesLd_o,
    output logic               timeout_o,
    output logic               gameOver_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [MIST_W-1:0]  mistakes_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic [TIMER_W-1:0] timeLeft_o,
    output logic [4:0]         stateOut_o
);

    typedef enum logic [4:0] {
        HALTED   = 5'd0,
        GENERATE = 5'd1,
        PAUSE    = 5'd2,
        CHECK    = 5'd3,
        UPDATE   = 5'd4,
        DONE     = 5'd5,
        TIMEOUT  = 5'd6
    } state_e;

    localparam logic [SCORE_W-1:0] SCORE_MAX    = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] STEP_L       = SCORE_W'(LEVEL_STEP);
    localparam logic [MIST_W-1:0]  MIST_MAX     = MIST_W'(MAX_MISTAKES);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX    = LEVEL_W'(MAX_LEVEL);
    localparam logic [TIMER_W-1:0] TIMEOUT_FULL = TIMER_W'(TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic               TIMEOUT_EN   = (TIMEOUT_CYC != 0);

    state_e             state_q, state_d;
    logic               enterPrev_q;
    logic               check_q, check_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MIST_W-1:0]  mistakes_q, mistakes_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic               seqLd_q, scoreLd_q, mistLd_q, timeout_q, gameOver_q;
    logic [TIMER_W-1:0] timeLeft_q;

    logic               enterEdge;
    logic [SCORE_W-1:0] scoreInc;
    logic [MIST_W-1:0]  mistInc;

    // A held button produces only one edge, so a press that started before
    // PAUSE (or in DONE) cannot trigger a second transition.
    assign enterEdge = enter_i & ~enterPrev_q;

    // Next-state and counter logic. Counters only move on the edge that
    // leaves HALTED, UPDATE or TIMEOUT; UPDATE trusts the verdict latched
    // in CHECK so a late change of sequenceCheck_i cannot affect scoring.
    always_comb begin
        state_d    = state_q;
        check_d    = check_q;
        score_d    = score_q;
        mistakes_d = mistakes_q;
        level_d    = level_q;
        timer_d    = timer_q;
        scoreInc   = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
        mistInc    = mistakes_q + MIST_W'(1);

        case (state_q)
            HALTED: begin
                score_d    = '0;
                mistakes_d = '0;
                level_d    = '0;
                timer_d    = '0;
                check_d    = 1'b0;
                state_d    = GENERATE;
            end
            GENERATE: begin
                timer_d = '0;
                state_d = PAUSE;
            end
            PAUSE: begin
                timer_d = timer_q + TIMER_W'(1);
                // A press on the last cycle of the window still counts.
                if (enterEdge) begin
                    state_d = CHECK;
                end else if (TIMEOUT_EN && (timer_q == TIMEOUT_LAST)) begin
                    state_d = TIMEOUT;
                end
            end
            CHECK: begin
                check_d = sequenceCheck_i;
                state_d = UPDATE;
            end
            UPDATE: begin
                if (check_q) begin
                    score_d = scoreInc;
                    if ((scoreInc != '0) && ((scoreInc % STEP_L) == '0)
                        && (level_q != LEVEL_MAX)) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                    state_d = GENERATE;
                end else begin
                    mistakes_d = mistInc;
                    state_d    = (mistInc == MIST_MAX) ? DONE : GENERATE;
                end
            end
            TIMEOUT: begin
                mistakes_d = mistInc;
                state_d    = (mistInc == MIST_MAX) ? DONE : GENERATE;
            end
            DONE: begin
                if (enterEdge) begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    // State, counters and outputs. Outputs are registered from the next
    // state so each strobe is high exactly during the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HALTED;
            enterPrev_q <= 1'b0;
            check_q     <= 1'b0;
            score_q     <= '0;
            mistakes_q  <= '0;
            level_q     <= '0;
            timer_q     <= '0;
            seqLd_q     <= 1'b0;
            scoreLd_q   <= 1'b0;
            mistLd_q    <= 1'b0;
            timeout_q   <= 1'b0;
            gameOver_q  <= 1'b0;
            timeLeft_q  <= '0;
        end else begin
            state_q     <= state_d;
            enterPrev_q <= enter_i;
            check_q     <= check_d;
            score_q     <= score_d;
            mistakes_q  <= mistakes_d;
            level_q     <= level_d;
            timer_q     <= timer_d;
            seqLd_q     <= (state_d == GENERATE);
            scoreLd_q   <= (state_d == UPDATE) && check_d;
            mistLd_q    <= ((state_d == UPDATE) && !check_d) || (state_d == TIMEOUT);
            timeout_q   <= (state_d == TIMEOUT);
            gameOver_q  <= (state_d == DONE);
            timeLeft_q  <= (state_d == PAUSE) ? (TIMEOUT_FULL - timer_d) : '0;
        end
    end

    assign sequenceLd_o = seqLd_q;
    assign scoreLd_o    = scoreLd_q;
    assign mistakesLd_o = mistLd_q;
    assign timeout_o    = timeout_q;
    assign gameOver_o   = gameOver_q;
    assign score_o      = score_q;
    assign mistakes_o   = mistakes_q;
    assign level_o      = level_q;
    assign timeLeft_o   = timeLeft_q;
    assign stateOut_o   = state_q;

endmodule

// File: tb/tb_game_control_timed.sv
// tb_game_control_timed
// Directed bench for game_control_timed with a short response window
// (8 cycles), 3 mistakes, a level every 2 points up to level 3 and a 4-bit
// score. A small reference model tracks score, level and mistakes.
module tb_game_control_timed;

    localparam int MAX_MISTAKES = 3;
    localparam int SCORE_W      = 4;
    localparam int TIMEOUT_CYC  = 8;
    localparam int TIMER_W      = 4;
    localparam int LEVEL_STEP   = 2;
    localparam int MAX_LEVEL    = 3;

    logic               clock;
    logic               rstN;
    logic               enter;
    logic               seqCheck;
    logic               seqLd;
    logic               scoreLd;
    logic               mistLd;
    logic               timeoutStb;
    logic               gameOver;
    logic [SCORE_W-1:0] score;
    logic [1:0]         mistakes;
    logic [1:0]         level;
    logic [TIMER_W-1:0] timeLeft;
    logic [4:0]         stateOut;

    int checkCount = 0;
    int errorCount = 0;
    int expScore   = 0;
    int expLevel   = 0;
    int expMist    = 0;

    game_control_timed #(
        .MAX_MISTAKES(MAX_MISTAKES),
        .SCORE_W     (SCORE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TIMER_W     (TIMER_W),
        .LEVEL_STEP  (LEVEL_STEP),
        .MAX_LEVEL   (MAX_LEVEL)
    ) dut (
        .clk_i          (clock),
        .rst_ni         (rstN),
        .enter_i        (enter),
        .sequenceCheck_i(seqCheck),
        .sequenceLd_o   (seqLd),
        .scoreLd_o      (scoreLd),
        .mistakesLd_o   (mistLd),
        .timeout_o      (timeoutStb),
        .gameOver_o     (gameOver),
        .score_o        (score),
        .mistakes_o     (mistakes),
        .level_o        (level),
        .timeLeft_o     (timeLeft),
        .stateOut_o     (stateOut)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive the two functional inputs
    task automatic applyStimulus(input logic enterVal, input logic checkVal);
        enter    = enterVal;
        seqCheck = checkVal;
    endtask

    // Advance one clock and settle just after the active edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One answered round, starting from the first cycle of PAUSE
    task automatic playRound(input logic c);
        applyStimulus(1'b1, c);
        step();
        checkOutput("round_check_state", stateOut, 3);
        checkOutput("round_check_noStrobe", {scoreLd, mistLd}, 0);
        applyStimulus(1'b0, c);
        step();
        checkOutput("round_update_state", stateOut, 4);
        checkOutput("round_score_ld", scoreLd, c);
        checkOutput("round_mistakes_ld", mistLd, !c);
        checkOutput("round_no_timeout", timeoutStb, 0);
        // verdict changes during UPDATE must be ignored
        applyStimulus(1'b0, !c);
        if (c) begin
            if (expScore < 15) expScore++;
            if (expScore != 0 && (expScore % LEVEL_STEP) == 0 && expLevel < MAX_LEVEL)
                expLevel++;
        end else begin
            expMist++;
        end
        step();
        checkOutput("round_score", score, expScore);
        checkOutput("round_level", level, expLevel);
        checkOutput("round_mistakes", mistakes, expMist);
        if (expMist == MAX_MISTAKES) begin
            checkOutput("round_done_state", stateOut, 5);
            checkOutput("round_game_over", gameOver, 1);
        end else begin
            checkOutput("round_gen_state", stateOut, 1);
            checkOutput("round_seq_ld", seqLd, 1);
            step();
            checkOutput("round_pause_state", stateOut, 2);
            checkOutput("round_time_left", timeLeft, 8);
        end
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0);
        step();
        step();
        // Reset values
        checkOutput("reset_state", stateOut, 0);
        checkOutput("reset_strobes", {seqLd, scoreLd, mistLd, timeoutStb, gameOver}, 0);
        checkOutput("reset_counters", {score, mistakes, level, timeLeft}, 0);

        // Release: no strobe on the release cycle, then HALTED->GENERATE->PAUSE
        rstN = 1'b1;
        #1;
        checkOutput("release_state", stateOut, 0);
        checkOutput("release_seq_ld", seqLd, 0);
        step();
        checkOutput("start_gen_state", stateOut, 1);
        checkOutput("start_seq_ld", seqLd, 1);
        step();
        checkOutput("start_pause_state", stateOut, 2);
        checkOutput("start_seq_ld_low", seqLd, 0);
        checkOutput("start_time_left0", timeLeft, 8);
        step();
        checkOutput("start_time_left1", timeLeft, 7);

        // Five correct rounds: score 1..5, level 0,1,1,2,2
        step();
        step();
        step();
        step();
        step();
        step();
        checkOutput("pre_round_time_left", timeLeft, 1);
        playRound(1'b1);
        checkOutput("r1_level", level, 0);
        for (int i = 0; i < 4; i++) playRound(1'b1);
        checkOutput("r5_score", score, 5);
        checkOutput("r5_level", level, 2);

        // Timeout: 8 PAUSE cycles without enter
        for (int i = 0; i < 7; i++) step();
        checkOutput("to_last_pause", stateOut, 2);
        checkOutput("to_last_time_left", timeLeft, 1);
        step();
        checkOutput("to_state", stateOut, 6);
        checkOutput("to_timeout_stb", timeoutStb, 1);
        checkOutput("to_mistakes_ld", mistLd, 1);
        checkOutput("to_time_left_zero", timeLeft, 0);
        expMist++;
        step();
        checkOutput("to_gen_state", stateOut, 1);
        checkOutput("to_mistakes", mistakes, 1);
        checkOutput("to_strobe_gone", {timeoutStb, mistLd}, 0);
        step();

        // Wrong answers until the game ends
        playRound(1'b0);
        checkOutput("wrong_mist2", mistakes, 2);
        playRound(1'b0);
        checkOutput("done_mist3", mistakes, 3);
        step();
        checkOutput("done_hold_state", stateOut, 5);
        checkOutput("done_hold_score", score, 5);

        // Enter edge in DONE, then held through GENERATE into PAUSE
        applyStimulus(1'b1, 1'b0);
        step();
        checkOutput("halt_state", stateOut, 0);
        checkOutput("halt_game_over", gameOver, 0);
        step();
        checkOutput("halt_gen_state", stateOut, 1);
        checkOutput("halt_cleared", {score, mistakes, level}, 0);
        expScore = 0;
        expLevel = 0;
        expMist  = 0;
        step();
        checkOutput("held_pause0", stateOut, 2);
        step();
        checkOutput("held_pause1", stateOut, 2);
        checkOutput("held_time_left", timeLeft, 7);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step();
        checkOutput("expiry_pause", stateOut, 2);
        checkOutput("expiry_time_left", timeLeft, 1);
        // Edge on the expiry cycle wins over timeout
        playRound(1'b1);

        // Saturation: 16 more correct rounds
        for (int i = 0; i < 16; i++) playRound(1'b1);
        checkOutput("sat_score", score, 15);
        checkOutput("sat_level", level, 3);
        checkOutput("sat_mistakes", mistakes, 0);

        // Asynchronous reset in the middle of PAUSE
        step();
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_state", stateOut, 0);
        checkOutput("async_counters", {score, mistakes, level, timeLeft}, 0);
        checkOutput("async_strobes", {seqLd, scoreLd, mistLd, timeoutStb, gameOver}, 0);
        step();
        rstN = 1'b1;
        #1;
        checkOutput("rerelease_strobes", {seqLd, scoreLd, mistLd, timeoutStb}, 0);
        step();
        checkOutput("rerelease_gen", stateOut, 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
